host_mem_model: RTL and testbench

//  Host-memory responder for the cache test bench: answers the memory controller's

---
 rtl/host_mem_model_pkg.sv | 13 +
 rtl/host_mem_model_if.sv | 33 +++
 rtl/host_mem_model_line_fifo.sv | 54 +++++
 rtl/host_mem_model.sv | 188 ++++++++++++++++++
 tb/tb_host_mem_model.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/host_mem_model_pkg.sv
// Shared types for the cache test-bench host-memory model.
package cache_test_pkg;

  localparam int unsigned LINE_W     = 512;
  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned LINE_SHIFT = $clog2(LINE_BYTES);

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {RdIdle, RdWait, RdFill, RdDrain} rd_state_t;
  typedef enum logic [1:0] {WrIdle, WrAccept, WrCommit} wr_state_t;

endpackage

// File: rtl/host_mem_model_if.sv
// Host-side read/write handshake between the memory controller (master) and host memory (slave).
interface host_mem_model_if;
  import cache_test_pkg::*;

  logic        rd_go;
  logic [63:0] rd_addr;
  logic [15:0] cache_lines;
  logic        rd_en;
  line_t       rd_data;
  logic        empty;
  logic        rd_done;

  logic        wr_go;
  logic [63:0] wr_addr;
  logic [15:0] wr_size;
  logic        wr_en;
  line_t       wr_data;
  logic        full;
  logic        wr_done;

  logic        proto_err;

  modport master (
    output rd_go, rd_addr, cache_lines, rd_en, wr_go, wr_addr, wr_size, wr_en, wr_data,
    input  rd_data, empty, rd_done, full, wr_done, proto_err
  );

  modport slave (
    input  rd_go, rd_addr, cache_lines, rd_en, wr_go, wr_addr, wr_size, wr_en, wr_data,
    output rd_data, empty, rd_done, full, wr_done, proto_err
  );

endinterface

// File: rtl/host_mem_model_line_fifo.sv
// Show-ahead line FIFO; a push into a full FIFO is accepted when a pop happens the same cycle.
module line_fifo #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Zero while empty so the output is clean after reset.
  assign dout    = empty ? '0 : store[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) store[wptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/host_mem_model.sv
// Host-memory responder: serves controller read/write handshakes from a line array with
// programmable latency, FIFO back-pressure and a sticky protocol-error flag.
module host_mem_model
  import cache_test_pkg::*;
#(
  parameter int unsigned LINES      = 1024,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int unsigned RD_LATENCY = 4,
  parameter int unsigned WR_LATENCY = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter string       INIT_FILE  = ""
) (
  input logic             clk,
  input logic             rst,
  host_mem_model_if.slave bus
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CntW = 16;

  typedef logic [IdxW-1:0] idx_t;

  function automatic idx_t line_index(logic [63:0] addr);
    return idx_t'((addr - BASE_ADDR) >> LINE_SHIFT);
  endfunction

  line_t mem [LINES];

  // Simulation preload; reset never touches the array.
  initial begin
    for (int unsigned i = 0; i < LINES; i++) mem[i] = '0;
  end

  rd_state_t       rd_state;
  idx_t            rd_idx;
  logic [15:0]     rd_left;
  logic [CntW-1:0] rd_cnt;
  logic            rd_done_q;

  wr_state_t       wr_state;
  idx_t            wr_idx;
  logic [15:0]     wr_left;
  logic [CntW-1:0] wr_cnt;
  logic            wr_full_q;
  logic            wr_done_q;

  logic            proto_err_q;
  logic            err_now;

  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  line_t           fifo_dout;
  logic [LvlW-1:0] level_q;
  logic            mem_we;

  assign pop    = bus.rd_en && !fifo_empty;
  assign push   = (rd_state == RdFill) && (!fifo_full || pop);
  assign mem_we = (wr_state == WrAccept) && bus.wr_en;

  // Combinational array read: a same-cycle write to this line lands after the push.
  line_fifo #(
    .WIDTH(LINE_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(1'b0),
    .din  (mem[rd_idx]),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= bus.wr_data;
  end

  // Occupancy lets DRAIN pulse rd_done in the same cycle the FIFO becomes empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= '0;
    else     level_q <= level_q + LvlW'(push) - LvlW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state  <= RdIdle;
      rd_idx    <= '0;
      rd_left   <= '0;
      rd_cnt    <= '0;
      rd_done_q <= 1'b0;
    end else begin
      rd_done_q <= 1'b0;
      unique case (rd_state)
        RdIdle: begin
          if (bus.rd_go) begin
            rd_idx   <= line_index(bus.rd_addr);
            rd_left  <= (bus.cache_lines == '0) ? 16'd1 : bus.cache_lines;
            rd_cnt   <= CntW'(RD_LATENCY);
            rd_state <= RdWait;
          end
        end
        RdWait: begin
          rd_cnt <= rd_cnt - 1'b1;
          if (rd_cnt == CntW'(1)) rd_state <= RdFill;
        end
        RdFill: begin
          if (push) begin
            rd_idx  <= rd_idx + 1'b1;
            rd_left <= rd_left - 16'd1;
            if (rd_left == 16'd1) rd_state <= RdDrain;
          end
        end
        RdDrain: begin
          if (fifo_empty || (pop && level_q == LvlW'(1))) begin
            rd_done_q <= 1'b1;
            rd_state  <= RdIdle;
          end
        end
        default: rd_state <= RdIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state  <= WrIdle;
      wr_idx    <= '0;
      wr_left   <= '0;
      wr_cnt    <= '0;
      wr_full_q <= 1'b1;
      wr_done_q <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      unique case (wr_state)
        WrIdle: begin
          if (bus.wr_go) begin
            wr_idx    <= line_index(bus.wr_addr);
            wr_left   <= (bus.wr_size == '0) ? 16'd1 : bus.wr_size;
            wr_full_q <= 1'b0;
            wr_state  <= WrAccept;
          end
        end
        WrAccept: begin
          if (bus.wr_en) begin
            wr_idx  <= wr_idx + 1'b1;
            wr_left <= wr_left - 16'd1;
            if (wr_left == 16'd1) begin
              wr_full_q <= 1'b1;
              wr_cnt    <= CntW'(WR_LATENCY);
              wr_state  <= WrCommit;
            end
          end
        end
        WrCommit: begin
          wr_cnt <= wr_cnt - 1'b1;
          if (wr_cnt == CntW'(1)) begin
            wr_done_q <= 1'b1;
            wr_state  <= WrIdle;
          end
        end
        default: wr_state <= WrIdle;
      endcase
    end
  end

  assign err_now = (bus.rd_go && rd_state != RdIdle) ||
                   (bus.wr_go && wr_state != WrIdle) ||
                   (bus.rd_en && fifo_empty) ||
                   (bus.wr_en && wr_full_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          proto_err_q <= 1'b0;
    else if (err_now) proto_err_q <= 1'b1;
  end

  assign bus.rd_data   = fifo_dout;
  assign bus.empty     = fifo_empty;
  assign bus.rd_done   = rd_done_q;
  assign bus.full      = wr_full_q;
  assign bus.wr_done   = wr_done_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_host_mem_model.sv
// Directed bench for host_mem_model: stimulus queues expected read lines, a negedge monitor
// pops and compares them whenever a FIFO pop happens.
module tb_host_mem_model;
  import cache_test_pkg::*;

  localparam int unsigned Lines = 1024;
  localparam logic [63:0] Base  = 64'h0000_0001_0000_0000;
  localparam int unsigned RdLat = 4;
  localparam int unsigned WrLat = 3;
  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  host_mem_model_if bus_if ();

  host_mem_model #(
    .LINES     (Lines),
    .BASE_ADDR (Base),
    .RD_LATENCY(RdLat),
    .WR_LATENCY(WrLat),
    .FIFO_DEPTH(Depth),
    .INIT_FILE ("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // 0: rd_en low, 1: rd_en = ~empty, 2: every other cycle while not empty, 3: forced high
  logic [1:0] rd_mode = 2'd0;
  logic       tog = 1'b0;
  assign bus_if.rd_en = (rd_mode == 2'd1) ? ~bus_if.empty :
                        (rd_mode == 2'd2) ? (tog & ~bus_if.empty) :
                        (rd_mode == 2'd3);

  line_t model [Lines];
  line_t exp_q [$];
  int    n_vec = 0;
  int    n_err = 0;
  int    n_pops = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [63:0] addr);
    logic [63:0] off;
    off = (addr - Base) >> 6;
    return int'(off % Lines);
  endfunction

  always @(negedge clk) begin
    if (!rst && bus_if.rd_en && !bus_if.empty) begin
      n_pops++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got %h, want none", bus_if.rd_data);
      end else begin
        line_t e;
        e = exp_q.pop_front();
        if (bus_if.rd_data !== e) begin
          n_err++;
          $display("FAIL rd_data: got %h, want %h", bus_if.rd_data, e);
        end
      end
    end
    if (!rst && bus_if.rd_done) chk("rd_done_while_empty", bus_if.empty, 1);
  end

  task automatic wr_req(input logic [63:0] addr, input int n, input line_t base_data);
    int idx;
    int cyc;
    idx = idx_of(addr);
    bus_if.wr_addr = addr;
    bus_if.wr_size = 16'(n);
    bus_if.wr_go   = 1'b1;
    tick();
    bus_if.wr_go = 1'b0;
    chk("wr_full_fall", bus_if.full, 0);
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      while (bus_if.full && cyc < 20) begin
        tick();
        cyc++;
      end
      bus_if.wr_en   = 1'b1;
      bus_if.wr_data = base_data + line_t'(i);
      model[(idx + i) % Lines] = bus_if.wr_data;
      tick();
    end
    bus_if.wr_en = 1'b0;
    chk("wr_full_rise", bus_if.full, 1);
    cyc = 0;
    while (!bus_if.wr_done && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("wr_done_latency", cyc + 1, WrLat + 1);
    tick();
    chk("wr_done_pulse", bus_if.wr_done, 0);
  endtask

  task automatic rd_req(input logic [63:0] addr, input int n);
    int idx;
    idx = idx_of(addr);
    for (int i = 0; i < ((n == 0) ? 1 : n); i++) exp_q.push_back(model[(idx + i) % Lines]);
    bus_if.rd_addr     = addr;
    bus_if.cache_lines = 16'(n);
    bus_if.rd_go       = 1'b1;
    tick();
    bus_if.rd_go = 1'b0;
  endtask

  task automatic wait_rd_done(input string name);
    int cyc;
    cyc = 0;
    while (!bus_if.rd_done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk(name, bus_if.rd_done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int pops0;
    int dones;
    bus_if.rd_go = 1'b0;  bus_if.rd_addr = '0; bus_if.cache_lines = '0;
    bus_if.wr_go = 1'b0;  bus_if.wr_addr = '0; bus_if.wr_size = '0;
    bus_if.wr_en = 1'b0;  bus_if.wr_data = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", bus_if.empty, 1);
    chk("rst_full", bus_if.full, 1);
    chk("rst_rd_done", bus_if.rd_done, 0);
    chk("rst_wr_done", bus_if.wr_done, 0);
    chk("rst_proto_err", bus_if.proto_err, 0);
    chk("rst_rd_data_zero", (bus_if.rd_data == '0), 1);
    rst = 1'b0;
    tick();

    // 1: single-line read latency and done timing
    wr_req(Base + 64'h140, 1, {16{32'hDEADBEEF}});
    rd_mode = 2'd1;
    pops0 = n_pops;
    rd_req(Base + 64'h140, 1);
    repeat (RdLat) tick();
    chk("rd_empty_hold", bus_if.empty, 1);
    tick();
    chk("rd_empty_fall", bus_if.empty, 0);
    tick();
    chk("rd_done_after_pop", bus_if.rd_done, 1);
    chk("t1_pops", n_pops - pops0, 1);
    tick();
    chk("rd_done_pulse", bus_if.rd_done, 0);

    // 2: write line 2, read back with cache_lines=0 (one line)
    wr_req(Base + 64'h80, 1, 512'hA5);
    pops0 = n_pops;
    rd_req(Base + 64'h80, 0);
    wait_rd_done("t2_rd_done");
    chk("t2_pops", n_pops - pops0, 1);

    // 3: wrap from line 1023 to 0, data held until popped
    wr_req(Base + (64'd1023 << 6), 3, {16{32'h3333_0000}});
    rd_mode = 2'd0;
    pops0 = n_pops;
    rd_req(Base + (64'd1023 << 6), 3);
    repeat (10) tick();
    chk("t3_fifo_loaded", bus_if.empty, 0);
    chk("t3_no_early_done", bus_if.rd_done, 0);
    rd_mode = 2'd1;
    wait_rd_done("t3_rd_done");
    chk("t3_pops_before_done", n_pops - pops0, 3);

    // 4: 8 lines through a 4-deep FIFO with intermittent pops
    wr_req(Base + 64'd6400, 8, {16{32'h4444_0000}});
    rd_mode = 2'd2;
    pops0 = n_pops;
    dones = 0;
    rd_req(Base + 64'd6400 + 64'h2A, 8);
    for (int i = 0; i < 60; i++) begin
      tog = ~tog;
      tick();
      if (bus_if.rd_done) dones++;
    end
    chk("t4_done_count", dones, 1);
    chk("t4_pops", n_pops - pops0, 8);
    chk("t4_proto_clean", bus_if.proto_err, 0);
    chk("t4_sb_drained", exp_q.size(), 0);

    // 5: protocol errors; in-flight read unaffected by an ignored rd_go
    bus_if.wr_en   = 1'b1;
    bus_if.wr_data = '1;
    tick();
    bus_if.wr_en = 1'b0;
    chk("t5_wr_en_full_err", bus_if.proto_err, 1);
    rd_mode = 2'd1;
    pops0 = n_pops;
    rd_req(Base + 64'h140, 1);
    bus_if.rd_addr     = Base;
    bus_if.cache_lines = 16'd5;
    bus_if.rd_go       = 1'b1;
    tick();
    bus_if.rd_go = 1'b0;
    wait_rd_done("t5_rd_done");
    chk("t5_pops", n_pops - pops0, 1);
    repeat (10) tick();
    chk("t5_ignored_req", bus_if.empty, 1);
    chk("t5_proto_sticky", bus_if.proto_err, 1);

    // 6: reset during FILL with two lines queued
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_proto_cleared", bus_if.proto_err, 0);
    rd_mode = 2'd0;
    rd_req(Base + 64'd6400, 4);
    repeat (RdLat + 2) tick();
    chk("t6_two_queued", bus_if.empty, 0);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("t6_rst_empty", bus_if.empty, 1);
    chk("t6_rst_full", bus_if.full, 1);
    chk("t6_rst_no_done", bus_if.rd_done, 0);
    rst = 1'b0;
    tick();
    chk("t6_no_done_after", bus_if.rd_done, 0);
    rd_mode = 2'd3;
    tick();
    rd_mode = 2'd0;
    chk("t6_rd_en_empty_err", bus_if.proto_err, 1);
    rd_mode = 2'd1;
    pops0 = n_pops;
    rd_req(Base + 64'h80, 1);
    wait_rd_done("t6_fresh_rd_done");
    chk("t6_fresh_pops", n_pops - pops0, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
